matrix_input_loader: RTL and testbench
======================================

# matrix_input_loader

- Upstream of the scalar-multiply unit.
- Collects an m×n matrix of 8-bit elements one at a time over a valid/ready handshake.
- Validates the dimensions and packs the elements into the team's flat 5×5 row-major matrix bus.
- Presents `matrix_out`, `m_out` and `n_out` as a stable, complete operand, signalled by `done`.

## Interface
- `DIM_MAX`, 5: maximum rows/columns; defines the bus stride.
- `ELEM_W`, 8: element width in bits.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a new matrix; samples `m_in`/`n_in`.
- `m_in`  in  3  requested row count.
- `n_in`  in  3  requested column count.
- `elem_valid`  in  1  `elem_data` holds the next element.
- `elem_data`  in  ELEM_W  element value, unsigned.
- `elem_ready`  out  1  loader accepts an element this cycle.
- `matrix_out`  out  DIM_MAX*DIM_MAX*ELEM_W (200)  packed matrix; element (r,c) at bits [(r*DIM_MAX+c)*ELEM_W +: ELEM_W].
- `m_out`  out  3  latched row count.
- `n_out`  out  3  latched column count.
- `row_idx`  out  3  row of the next element to be written.
- `col_idx`  out  3  column of the next element to be written.
- `busy`  out  1  loading in progress.
- `done`  out  1  matrix complete and valid; level.
- `dim_error`  out  1  last `start` carried illegal dimensions; level.

## Operation
- States: IDLE, LOAD, DONE, ERR.
- Legal dimensions: 1 ≤ `m_in` ≤ DIM_MAX and 1 ≤ `n_in` ≤ DIM_MAX.
- `start` in any state, legal dimensions:
  - latch `m_out`/`n_out`, clear `matrix_out` to all zeros, clear `row_idx`/`col_idx`;
  - go to LOAD.
- `start` in any state, illegal dimensions:
  - go to ERR;
  - `matrix_out`, `m_out` and `n_out` keep their previous values.
- LOAD:
  - `elem_ready`=1.
  - On `elem_valid`&`elem_ready`, write `elem_data` at (`row_idx`,`col_idx`).
  - If `col_idx`==`n_out`-1: set `col_idx`=0 and increment `row_idx`; otherwise increment `col_idx`.
  - The accept at (`m_out`-1,`n_out`-1) moves to DONE; indices stay at that last position.
- DONE: `done`=1; `matrix_out` is frozen. Leave only on `start` or `reset`.
- ERR: `dim_error`=1. Leave only on `start` or `reset`.
- IDLE: all flags 0. Entered only from reset.
- Decoded outputs:
  - `elem_ready`=`busy`=(state==LOAD);
  - `done`=(state==DONE);
  - `dim_error`=(state==ERR).
- A `start` in the same cycle as an element handshake takes priority: the element is discarded and loading restarts. `elem_ready` is still 1 in that cycle.
- In LOAD, `elem_valid` low holds all state; there is no timeout.
- Bytes outside the m×n region are always 0 after a legal `start`.

## Timing
- Reset values: state IDLE; `matrix_out`=0; `m_out`=`n_out`=0; `row_idx`=`col_idx`=0; `elem_ready`=`busy`=`done`=`dim_error`=0.
- `start` at edge k: LOAD, and `elem_ready`=1, from cycle k+1.
- Each accepted element appears on `matrix_out` in the cycle after its handshake edge.
- `done` rises in the cycle after the m·n-th accept. Minimum time from `start` to `done` is m·n+1 cycles.
- `dim_error` rises in the cycle after an illegal `start`.
- `reset` mid-LOAD: next cycle matches the reset values exactly, and a partial matrix is never flagged `done`.

## Test plan
- **2×3 load.**
  - Stimulus: `start` with m=2, n=3; then back-to-back 1,2,3,3,4,5.
  - Required: bytes at bit offsets 0,8,16,40,48,56 = 1,2,3,3,4,5; all other bytes 0; `done`=1 exactly 7 cycles after `start`; `m_out`=2, `n_out`=3.
  - Chained to scalar-multiply with scalar 3, the result is 3,6,9,9,12,15.
- **Gapped valid.**
  - Stimulus: 3×2 load with `elem_valid` low for 2 cycles between elements.
  - Required: `row_idx`/`col_idx` hold during the gaps; final matrix correct; `done` only after the 6th accept.
- **Illegal dimensions.**
  - Stimulus: `start` with m=0, n=3; then `start` with m=2, n=6.
  - Required: `dim_error`=1 from the next cycle; `elem_ready` stays 0; `matrix_out`, `m_out` and `n_out` unchanged from the prior DONE matrix.
- **Restart mid-load.**
  - Stimulus: 4 of 9 elements of a 3×3 load, then `start` 2×2 in the same cycle as `elem_valid`=1.
  - Required: that element is dropped; `matrix_out`=0 and indices 0 next cycle; 2×2 completes normally.
- **Full 5×5 load.**
  - Stimulus: 25 elements, values 1..25.
  - Required: byte at offset 192 = 25; `row_idx`=4, `col_idx`=4 in DONE; `done` 26 cycles after `start`.
- **Reset mid-load.**
  - Stimulus: assert `reset` after 3 elements.
  - Required: next cycle all outputs at reset values; `done` never asserts.

Source files
------------

// File: rtl/matrix_input_loader.sv
// Collects an m x n matrix element-by-element into a flat DIM_MAX x DIM_MAX row-major bus; each element lands 1 cycle after its handshake.
// elem_ready is high for the whole LOAD state (no internal backpressure); start always wins over a same-cycle element.
module matrix_input_loader #(
  parameter int DIM_MAX = 5,
  parameter int ELEM_W  = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [2:0]                        m_in,
  input  logic [2:0]                        n_in,
  input  logic                              elem_valid,
  input  logic [ELEM_W-1:0]                 elem_data,
  output logic                              elem_ready,
  output logic [DIM_MAX*DIM_MAX*ELEM_W-1:0] matrix_out,
  output logic [2:0]                        m_out,
  output logic [2:0]                        n_out,
  output logic [2:0]                        row_idx,
  output logic [2:0]                        col_idx,
  output logic                              busy,
  output logic                              done,
  output logic                              dim_error
);

  localparam int CELLS = DIM_MAX * DIM_MAX;
  localparam int POS_W = $clog2(CELLS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]       state;
  logic             dims_legal;
  logic             accept;
  logic             col_last;
  logic             row_last;
  logic [POS_W-1:0] elem_pos;

  assign dims_legal = (m_in != 3'd0) && (int'(m_in) <= DIM_MAX) &&
                      (n_in != 3'd0) && (int'(n_in) <= DIM_MAX);
  assign accept     = (state == S_LOAD) && elem_valid && !start;
  assign col_last   = (col_idx == n_out - 3'd1);
  assign row_last   = (row_idx == m_out - 3'd1);
  assign elem_pos   = POS_W'(row_idx) * POS_W'(DIM_MAX) + POS_W'(col_idx);

  assign elem_ready = (state == S_LOAD);
  assign busy       = (state == S_LOAD);
  assign done       = (state == S_DONE);
  assign dim_error  = (state == S_ERR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      matrix_out <= '0;
      m_out      <= 3'd0;
      n_out      <= 3'd0;
      row_idx    <= 3'd0;
      col_idx    <= 3'd0;
    end else if (start) begin
      // Illegal dimensions leave the previous operand untouched for downstream.
      if (dims_legal) begin
        state      <= S_LOAD;
        matrix_out <= '0;
        m_out      <= m_in;
        n_out      <= n_in;
        row_idx    <= 3'd0;
        col_idx    <= 3'd0;
      end else begin
        state <= S_ERR;
      end
    end else if (accept) begin
      for (int i = 0; i < CELLS; i++) begin
        if (elem_pos == POS_W'(i))
          matrix_out[i*ELEM_W +: ELEM_W] <= elem_data;
      end
      // Indices park on the final element once the matrix is complete.
      if (col_last && row_last) begin
        state <= S_DONE;
      end else if (col_last) begin
        col_idx <= 3'd0;
        row_idx <= row_idx + 3'd1;
      end else begin
        col_idx <= col_idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_matrix_input_loader.sv
// Directed bench for matrix_input_loader: inputs change 1ns after the rising edge, outputs are checked there too.
module tb_matrix_input_loader;

  logic         clk;
  logic         reset;
  logic         start;
  logic [2:0]   m_in;
  logic [2:0]   n_in;
  logic         elem_valid;
  logic [7:0]   elem_data;
  logic         elem_ready;
  logic [199:0] matrix_out;
  logic [2:0]   m_out;
  logic [2:0]   n_out;
  logic [2:0]   row_idx;
  logic [2:0]   col_idx;
  logic         busy;
  logic         done;
  logic         dim_error;

  int n_checks = 0;
  int n_pass   = 0;

  matrix_input_loader #(.DIM_MAX(5), .ELEM_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .m_in(m_in), .n_in(n_in),
    .elem_valid(elem_valid), .elem_data(elem_data), .elem_ready(elem_ready),
    .matrix_out(matrix_out), .m_out(m_out), .n_out(n_out),
    .row_idx(row_idx), .col_idx(col_idx), .busy(busy), .done(done),
    .dim_error(dim_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [2:0] m, input logic [2:0] n);
    start = 1'b1; m_in = m; n_in = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] v);
    elem_valid = 1'b1; elem_data = v;
    tick();
    elem_valid = 1'b0;
  endtask

  // {elem_ready, busy, done, dim_error}
  function automatic logic [3:0] flags();
    return {elem_ready, busy, done, dim_error};
  endfunction

  logic [199:0] exp_mat;
  logic [199:0] prev_mat;
  logic [7:0]   vals [6];
  int           pos  [6];
  logic [2:0]   er   [6];
  logic [2:0]   ec   [6];
  int           done_seen;

  initial begin
    reset = 1'b1; start = 1'b0; m_in = 3'd0; n_in = 3'd0;
    elem_valid = 1'b0; elem_data = 8'd0;
    tick(); tick();
    reset = 1'b0;
    check("reset_matrix", matrix_out, '0);
    check("reset_dims", {m_out, n_out}, 6'd0);
    check("reset_idx", {row_idx, col_idx}, 6'd0);
    check("reset_flags", flags(), 4'b0000);
    tick();
    check("idle_flags", flags(), 4'b0000);

    // 2x3 back-to-back load
    do_start(3'd2, 3'd3);
    check("t1_load_flags", flags(), 4'b1100);
    check("t1_dims", {m_out, n_out}, {3'd2, 3'd3});
    vals = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd4, 8'd5};
    pos  = '{0, 1, 2, 5, 6, 7};
    exp_mat = '0;
    for (int i = 0; i < 6; i++) begin
      send(vals[i]);
      exp_mat[pos[i]*8 +: 8] = vals[i];
      check($sformatf("t1_elem%0d", i), matrix_out, exp_mat);
      if (i == 4) check("t1_done_early", done, 1'b0);
    end
    check("t1_done_at_7", flags(), 4'b0010);
    check("t1_last_idx", {row_idx, col_idx}, {3'd1, 3'd2});
    begin
      logic [47:0] scaled;
      for (int i = 0; i < 6; i++) scaled[i*8 +: 8] = matrix_out[pos[i]*8 +: 8] * 8'd3;
      check("t1_scaled_x3", scaled, {8'd15, 8'd12, 8'd9, 8'd9, 8'd6, 8'd3});
    end
    elem_valid = 1'b1; elem_data = 8'hEE;
    tick(); tick();
    elem_valid = 1'b0;
    check("t1_frozen", matrix_out, exp_mat);
    check("t1_still_done", flags(), 4'b0010);
    prev_mat = exp_mat;

    // Illegal dimensions keep the prior DONE operand
    do_start(3'd0, 3'd3);
    check("t3_m0_flags", flags(), 4'b0001);
    check("t3_m0_matrix", matrix_out, prev_mat);
    check("t3_m0_dims", {m_out, n_out}, {3'd2, 3'd3});
    elem_valid = 1'b1; elem_data = 8'h77;
    tick();
    elem_valid = 1'b0;
    check("t3_err_ignores_elem", matrix_out, prev_mat);
    do_start(3'd2, 3'd6);
    check("t3_n6_flags", flags(), 4'b0001);
    check("t3_n6_matrix", matrix_out, prev_mat);
    check("t3_n6_dims", {m_out, n_out}, {3'd2, 3'd3});

    // 3x2 load with two idle cycles between elements
    do_start(3'd3, 3'd2);
    check("t2_cleared", matrix_out, '0);
    vals = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15};
    pos  = '{0, 1, 5, 6, 10, 11};
    er   = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2};
    ec   = '{3'd1, 3'd0, 3'd1, 3'd0, 3'd1, 3'd1};
    exp_mat = '0;
    for (int i = 0; i < 6; i++) begin
      send(vals[i]);
      exp_mat[pos[i]*8 +: 8] = vals[i];
      check($sformatf("t2_idx%0d", i), {row_idx, col_idx}, {er[i], ec[i]});
      if (i < 5) begin
        check($sformatf("t2_not_done%0d", i), done, 1'b0);
        tick(); tick();
        check($sformatf("t2_gap_hold%0d", i), {row_idx, col_idx}, {er[i], ec[i]});
      end
    end
    check("t2_matrix", matrix_out, exp_mat);
    check("t2_done", flags(), 4'b0010);

    // Restart mid-load: start wins over a simultaneous element
    do_start(3'd3, 3'd3);
    for (int i = 0; i < 4; i++) send(8'(21 + i));
    check("t4_idx_after4", {row_idx, col_idx}, {3'd1, 3'd1});
    start = 1'b1; m_in = 3'd2; n_in = 3'd2;
    elem_valid = 1'b1; elem_data = 8'd99;
    check("t4_ready_with_start", elem_ready, 1'b1);
    tick();
    start = 1'b0; elem_valid = 1'b0;
    check("t4_matrix_cleared", matrix_out, '0);
    check("t4_idx_cleared", {row_idx, col_idx}, 6'd0);
    check("t4_dims", {m_out, n_out}, {3'd2, 3'd2});
    exp_mat = '0;
    pos = '{0, 1, 5, 6, 0, 0};
    for (int i = 0; i < 4; i++) begin
      send(8'(31 + i));
      exp_mat[pos[i]*8 +: 8] = 8'(31 + i);
    end
    check("t4_matrix", matrix_out, exp_mat);
    check("t4_done", flags(), 4'b0010);

    // Full 5x5
    do_start(3'd5, 3'd5);
    exp_mat = '0;
    for (int i = 0; i < 25; i++) begin
      send(8'(i + 1));
      exp_mat[i*8 +: 8] = 8'(i + 1);
      if (i == 23) check("t5_done_early", done, 1'b0);
    end
    check("t5_done_at_26", flags(), 4'b0010);
    check("t5_byte192", matrix_out[192 +: 8], 8'd25);
    check("t5_matrix", matrix_out, exp_mat);
    check("t5_idx", {row_idx, col_idx}, {3'd4, 3'd4});

    // Reset mid-load
    do_start(3'd3, 3'd3);
    for (int i = 0; i < 3; i++) send(8'(50 + i));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_matrix", matrix_out, '0);
    check("t6_dims", {m_out, n_out}, 6'd0);
    check("t6_idx", {row_idx, col_idx}, 6'd0);
    check("t6_flags", flags(), 4'b0000);
    done_seen = 0;
    elem_valid = 1'b1; elem_data = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || elem_ready) done_seen++;
    end
    elem_valid = 1'b0;
    check("t6_never_done", done_seen, 0);
    check("t6_matrix_idle", matrix_out, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
